// File: rtl/ping_pong_game_if.sv
// Board-side signal bundle of the ping-pong game box: the two raw push-buttons,
// the 8 ball LEDs and the 3-wire 74HC595 bus (SER, SRCLK, RCLK).
interface ping_pong_game_if;
  logic       key_player1;
  logic       key_player2;
  logic [7:0] position;
  logic       driver_pin_1;
  logic       driver_pin_2;
  logic       driver_pin_3;

  // Board / test side: drives the buttons, observes LEDs and the display bus.
  modport master (
    output key_player1, key_player2,
    input  position, driver_pin_1, driver_pin_2, driver_pin_3
  );

  // Game controller side.
  modport slave (
    input  key_player1, key_player2,
    output position, driver_pin_1, driver_pin_2, driver_pin_3
  );
endinterface

// File: rtl/ping_pong_game.sv
// Two-player LED ping-pong controller: key synchronizing/debouncing, rally FSM,
// score keeping and a continuous 16-bit score frame to two cascaded 74HC595s.
module ping_pong_game #(
  parameter int STEP_CYCLES     = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SHIFT_DIV       = 25,
  parameter int HIT_ZONE        = 3,
  parameter int WIN_SCORE       = 9
) (
  input  logic           clk,
  input  logic           rst,
  ping_pong_game_if.slave io
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW  = $clog2(STEP_CYCLES + 1);
  localparam int DVW = $clog2(SHIFT_DIV + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBW-1:0] DB_ONE    = DBW'(1);
  localparam logic [SW-1:0]  STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [SW-1:0]  STEP_ONE  = SW'(1);
  localparam logic [DVW-1:0] DIV_LAST  = DVW'(SHIFT_DIV - 1);
  localparam logic [DVW-1:0] DIV_ONE   = DVW'(1);
  localparam logic [7:0]     ZONE_L    = 8'((1 << HIT_ZONE) - 1);
  localparam logic [7:0]     ZONE_H    = 8'(((1 << HIT_ZONE) - 1) << (8 - HIT_ZONE));
  localparam logic [3:0]     WIN       = 4'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE, FLY_L, FLY_H, OVER} state_t;

  // Common-cathode gfedcba code, dp kept dark.
  function automatic logic [7:0] seg7(input logic [3:0] val);
    case (val)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  // ---------------- key conditioning (index 0 = player 1, 1 = player 2)
  logic [1:0]     key_raw_s;
  logic [1:0]     sync1_q, sync2_q, level_q, press_q;
  logic [DBW-1:0] db_cnt_q [2];

  assign key_raw_s = {io.key_player2, io.key_player1};

  // Two-FF synchronizer, stability counter and one-clock press pulse on a debounced fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      level_q     <= 2'b11;
      press_q     <= 2'b00;
      db_cnt_q[0] <= {DBW{1'b0}};
      db_cnt_q[1] <= {DBW{1'b0}};
    end else begin
      sync1_q <= key_raw_s;
      sync2_q <= sync1_q;
      press_q <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        if (sync2_q[k] == level_q[k]) begin
          db_cnt_q[k] <= {DBW{1'b0}};
        end else if (db_cnt_q[k] == DB_LAST) begin
          db_cnt_q[k] <= {DBW{1'b0}};
          level_q[k]  <= sync2_q[k];
          press_q[k]  <= ~sync2_q[k];
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + DB_ONE;
        end
      end
    end
  end

  // ---------------- rally state machine
  state_t         state_q, state_d;
  logic [7:0]     pos_q, pos_d;
  logic [3:0]     score1_q, score1_d, score2_q, score2_d;
  logic [SW-1:0]  step_q, step_d;
  logic           step_exp_s, point1_s, point2_s;

  assign step_exp_s = (step_q == STEP_LAST);

  // Game state, ball position, scores and step timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pos_q    <= 8'h00;
      score1_q <= 4'd0;
      score2_q <= 4'd0;
      step_q   <= {SW{1'b0}};
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      step_q   <= step_d;
    end
  end

  // Next-state logic; a receiver press wins over a same-clock step (judged before the shift).
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    score1_d = score1_q;
    score2_d = score2_q;
    step_d   = step_q + STEP_ONE;
    point1_s = 1'b0;
    point2_s = 1'b0;
    case (state_q)
      IDLE: begin
        pos_d  = 8'h00;
        step_d = {SW{1'b0}};
        if (press_q[0]) begin
          pos_d   = 8'h80;
          state_d = FLY_L;
        end else if (press_q[1]) begin
          pos_d   = 8'h01;
          state_d = FLY_H;
        end else begin
          state_d = IDLE;
        end
      end
      FLY_L: begin
        if (press_q[1]) begin
          if ((pos_q & ZONE_L) != 8'h00) begin
            state_d = FLY_H;
            step_d  = {SW{1'b0}};
          end else begin
            point1_s = 1'b1;
          end
        end else if (step_exp_s) begin
          step_d = {SW{1'b0}};
          if (pos_q[0]) begin
            point1_s = 1'b1;
          end else begin
            pos_d = pos_q >> 1;
          end
        end else begin
          pos_d = pos_q;
        end
      end
      FLY_H: begin
        if (press_q[0]) begin
          if ((pos_q & ZONE_H) != 8'h00) begin
            state_d = FLY_L;
            step_d  = {SW{1'b0}};
          end else begin
            point2_s = 1'b1;
          end
        end else if (step_exp_s) begin
          step_d = {SW{1'b0}};
          if (pos_q[7]) begin
            point2_s = 1'b1;
          end else begin
            pos_d = pos_q << 1;
          end
        end else begin
          pos_d = pos_q;
        end
      end
      OVER: begin
        pos_d  = 8'hFF;
        step_d = {SW{1'b0}};
      end
      default: begin
        state_d = IDLE;
        pos_d   = 8'h00;
      end
    endcase

    if (point1_s) begin
      score1_d = score1_q + 4'd1;
      step_d   = {SW{1'b0}};
      if (score1_d == WIN) begin
        state_d = OVER;
        pos_d   = 8'hFF;
      end else begin
        state_d = IDLE;
        pos_d   = 8'h00;
      end
    end else if (point2_s) begin
      score2_d = score2_q + 4'd1;
      step_d   = {SW{1'b0}};
      if (score2_d == WIN) begin
        state_d = OVER;
        pos_d   = 8'hFF;
      end else begin
        state_d = IDLE;
        pos_d   = 8'h00;
      end
    end else begin
      score1_d = score1_q;
    end
  end

  // ---------------- 595 display frame: phases 0..31 carry 16 bits (odd = SRCLK high),
  // phase 32 = RCLK high, phase 33 = RCLK low; each phase lasts SHIFT_DIV clocks.
  logic [DVW-1:0] div_q, div_d;
  logic [5:0]     ph_q, ph_d;
  logic [15:0]    frame_q, frame_d;
  logic           ser_q, ser_d, srclk_q, srclk_d, rclk_q, rclk_d;
  logic [3:0]     bit_idx_s;

  // Phase timing, frame sampling at frame start and next values of the three bus pins.
  always_comb begin
    div_d   = div_q + DIV_ONE;
    ph_d    = ph_q;
    frame_d = frame_q;
    if (div_q == DIV_LAST) begin
      div_d = {DVW{1'b0}};
      if (ph_q == 6'd33) begin
        ph_d    = 6'd0;
        frame_d = {seg7(score1_q), seg7(score2_q)};
      end else begin
        ph_d = ph_q + 6'd1;
      end
    end else begin
      ph_d = ph_q;
    end
    bit_idx_s = 4'd15 - ph_d[4:1];
    srclk_d   = (ph_d < 6'd32) && ph_d[0];
    rclk_d    = (ph_d == 6'd32);
    if (ph_d < 6'd32) begin
      ser_d = frame_d[bit_idx_s];
    end else begin
      ser_d = 1'b0;
    end
  end

  // Display counters, frame latch and registered bus pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= {DVW{1'b0}};
      ph_q    <= 6'd0;
      frame_q <= 16'h3F3F;
      ser_q   <= 1'b0;
      srclk_q <= 1'b0;
      rclk_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      ph_q    <= ph_d;
      frame_q <= frame_d;
      ser_q   <= ser_d;
      srclk_q <= srclk_d;
      rclk_q  <= rclk_d;
    end
  end

  assign io.position     = pos_q;
  assign io.driver_pin_1 = ser_q;
  assign io.driver_pin_2 = srclk_q;
  assign io.driver_pin_3 = rclk_q;

endmodule

// File: tb/tb_ping_pong_game.sv
// Directed bench for ping_pong_game with small timing parameters; expected values
// go into a scoreboard queue and are popped when the DUT output is sampled.
module tb_ping_pong_game;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ping_pong_game_if bus ();

  ping_pong_game #(
    .STEP_CYCLES(50), .DEBOUNCE_CYCLES(5), .SHIFT_DIV(2), .HIT_ZONE(3), .WIN_SCORE(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  // Receiving 595 model: shift on SRCLK rise, latch on RCLK rise.
  logic [15:0] sh_r, disp_r;
  logic        srclk_prev, rclk_prev;
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      sh_r <= 16'h0000; disp_r <= 16'h0000; srclk_prev <= 1'b0; rclk_prev <= 1'b0;
    end else begin
      if (bus.driver_pin_2 && !srclk_prev) sh_r <= {sh_r[14:0], bus.driver_pin_1};
      if (bus.driver_pin_3 && !rclk_prev) disp_r <= sh_r;
      srclk_prev <= bus.driver_pin_2;
      rclk_prev  <= bus.driver_pin_3;
    end
  end

  task automatic push_exp(input string t, input logic [15:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic check(input logic [15:0] obs);
    logic [15:0] e;
    string t;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic chk_pos(input string t, input logic [7:0] e);
    push_exp(t, {8'h00, e});
    check({8'h00, bus.position});
  endtask

  task automatic chk_disp(input string t, input logic [15:0] e);
    push_exp(t, e);
    check(disp_r);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.key_player1 = 1'b1;
    bus.key_player2 = 1'b1;
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;

    // Idle after reset.
    wait_clk(1000);
    chk_pos("reset_pos", 8'h00);
    chk_disp("reset_disp", 16'h3F3F);

    // Player 1 serves; player 2 fouls at 0x40.
    bus.key_player1 = 1'b0;
    wait_clk(7);
    chk_pos("serve1_latency", 8'h00);
    wait_clk(1);
    chk_pos("serve1", 8'h80);
    bus.key_player1 = 1'b1;
    wait_clk(49);
    chk_pos("serve1_hold", 8'h80);
    wait_clk(1);
    chk_pos("step_40", 8'h40);
    bus.key_player2 = 1'b0;
    wait_clk(8);
    chk_pos("foul_p2", 8'h00);
    bus.key_player2 = 1'b1;
    wait_clk(200);
    chk_disp("disp_1_0", 16'h063F);

    // Player 2 serves; ball runs to bit 7 and player 1 misses.
    bus.key_player2 = 1'b0;
    wait_clk(8);
    chk_pos("serve2", 8'h01);
    bus.key_player2 = 1'b1;
    wait_clk(349);
    chk_pos("fly_h_40", 8'h40);
    wait_clk(1);
    chk_pos("fly_h_80", 8'h80);
    wait_clk(49);
    chk_pos("fly_h_80_hold", 8'h80);
    wait_clk(1);
    chk_pos("miss_p1", 8'h00);
    wait_clk(200);
    chk_disp("disp_1_1", 16'h0606);
    chk_pos("idle_after_miss", 8'h00);

    // Player 1 serves; legal return at 0x04, then player 1 misses at bit 7.
    bus.key_player1 = 1'b0;
    wait_clk(8);
    chk_pos("serve1_b", 8'h80);
    bus.key_player1 = 1'b1;
    wait_clk(250);
    chk_pos("ball_04", 8'h04);
    bus.key_player2 = 1'b0;
    wait_clk(8);
    chk_pos("return_hold", 8'h04);
    bus.key_player2 = 1'b1;
    wait_clk(49);
    chk_pos("return_wait", 8'h04);
    wait_clk(1);
    chk_pos("return_step", 8'h08);
    wait_clk(200);
    chk_pos("return_80", 8'h80);
    wait_clk(50);
    chk_pos("miss_p1_b", 8'h00);
    wait_clk(200);
    chk_disp("disp_1_2", 16'h065B);

    // Bouncing key: short glitches never become a press.
    for (int g = 0; g < 3; g++) begin
      bus.key_player1 = 1'b0;
      wait_clk(3);
      bus.key_player1 = 1'b1;
      wait_clk(3);
    end
    wait_clk(20);
    chk_pos("bounce_ignored", 8'h00);

    // Both keys in the same clock: player 1 serves.
    bus.key_player1 = 1'b0;
    bus.key_player2 = 1'b0;
    wait_clk(8);
    chk_pos("both_serve", 8'h80);
    bus.key_player1 = 1'b1;
    bus.key_player2 = 1'b1;
    wait_clk(10);
    chk_pos("both_hold", 8'h80);
    bus.key_player2 = 1'b0;
    wait_clk(8);
    chk_pos("foul_p2_b", 8'h00);
    bus.key_player2 = 1'b1;

    // Fresh game: nine fouls by player 2 end the game.
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(10);
    for (int i = 1; i <= 9; i++) begin
      bus.key_player1 = 1'b0;
      wait_clk(8);
      bus.key_player1 = 1'b1;
      bus.key_player2 = 1'b0;
      wait_clk(8);
      bus.key_player2 = 1'b1;
      chk_pos($sformatf("foul_%0d", i), (i == 9) ? 8'hFF : 8'h00);
      wait_clk(10);
    end
    wait_clk(200);
    chk_disp("disp_9_0", 16'h6F3F);
    bus.key_player1 = 1'b0;
    wait_clk(8);
    bus.key_player1 = 1'b1;
    wait_clk(60);
    chk_pos("over_key1", 8'hFF);
    bus.key_player2 = 1'b0;
    wait_clk(8);
    bus.key_player2 = 1'b1;
    wait_clk(60);
    chk_pos("over_key2", 8'hFF);

    // Asynchronous reset mid-frame clears every output at once.
    wait_clk(7);
    #2;
    rst = 1'b1;
    #1;
    push_exp("rst_outputs", 16'h0000);
    check({bus.position, 5'b00000, bus.driver_pin_1, bus.driver_pin_2, bus.driver_pin_3});
    wait_clk(2);
    rst = 1'b0;
    wait_clk(200);
    chk_pos("post_rst_pos", 8'h00);
    chk_disp("post_rst_disp", 16'h3F3F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
